rv32i_mem_pipe: RTL and testbench
=================================

Name: rv32i_mem_pipe

Overview:
Memory-access stage directly downstream of the ALU stage in the rv32i pipeline. It consumes the ALU result as an effective address or a pass-through value. It runs RV32I loads and stores over a single-outstanding request/ack data bus and hands register-writeback data to the writeback stage. While a bus transaction is in flight it back-pressures the upstream stages through stall_o.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TIMEOUT, 255, cycles in BUS_WAIT without ack before abort (1..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
data_ready_i  in  1  valid input from ALU stage
mem_op_i  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
funct3_i  in  3  RV32I load/store width/sign field
alu_result_i  in  XLEN  effective address (mem ops) or pass-through result
store_data_i  in  XLEN  rs2 value for stores
rd_i  in  5  destination register
reg_write_i  in  1  instruction writes rd
clear_i  in  1  pipeline flush
stall_o  out  1  stage busy; upstream holds inputs
data_ready_o  out  1  output valid pulse
result_o  out  XLEN  writeback data
rd_o  out  5  destination register
reg_write_o  out  1  writeback enable qualified
fault_o  out  1  pulse with data_ready_o: misaligned, illegal funct3, or bus timeout
bus_req_o  out  1  bus request
bus_we_o  out  1  write strobe
bus_addr_o  out  XLEN-2  word address (alu_result_i[XLEN-1:2])
bus_be_o  out  4  byte enables
bus_wdata_o  out  XLEN  write data
bus_rdata_i  in  XLEN  read data, valid with ack
bus_ack_i  in  1  transaction complete

Behaviour:
- Reset (rst_i): state IDLE; all outputs 0; timeout counter 0. This applies in any state and abandons an in-flight request, with bus_req_o low the next cycle.
- States: IDLE, BUS_WAIT. stall_o = (state == BUS_WAIT). Inputs presented while stall_o is high are ignored.
- IDLE, data_ready_i=1, clear_i=0:
  - mem_op none or reserved: next cycle data_ready_o=1, result_o=alu_result_i, rd_o/reg_write_o copied, fault_o=0. Latency 1.
  - Load/store, aligned, legal funct3: next cycle bus_req_o=1, bus_we_o=(store), bus_addr_o/bus_be_o/bus_wdata_o registered, state goes to BUS_WAIT, counter cleared.
  - Misaligned or illegal funct3: no bus request. Next cycle data_ready_o=1, fault_o=1, reg_write_o=0, result_o=alu_result_i.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other funct3 values are illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- Byte enables:
  - Byte: 0001 shifted left by addr[1:0].
  - Half: addr[1] ? 1100 : 0011.
  - Word: 1111.
  - Loads use the same enables.
- Store data: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
- BUS_WAIT: bus outputs held stable; counter increments each cycle.
  - bus_ack_i=1: next cycle bus_req_o=0, state IDLE, data_ready_o=1.
    - Load: result_o = selected lane of bus_rdata_i, sign- or zero-extended per funct3; reg_write_o = latched reg_write.
    - Store: result_o=0, reg_write_o=0.
  - Counter reaches TIMEOUT without ack: next cycle bus_req_o=0, state IDLE, data_ready_o=1, fault_o=1, reg_write_o=0.
  - Ack on the same cycle the counter reaches TIMEOUT: the ack wins and no fault is raised.
- clear_i:
  - In IDLE: input suppressed, data_ready_o=0 next cycle.
  - In BUS_WAIT: the transaction is not aborted and continues until ack or timeout. The flush is latched, and on completion data_ready_o stays 0 and no fault is reported.
  - rst_i has priority over clear_i.
- data_ready_o and fault_o are single-cycle pulses. result_o, rd_o and reg_write_o hold until the next data_ready_o.

Test Plan:
- ALU pass-through: mem_op=00, alu_result=0x0000_1234, rd=5, reg_write=1 -> one cycle later data_ready_o=1, result_o=0x1234, rd_o=5, stall_o never high.
- LB sign-extension: addr=0x103, ack after 3 cycles with rdata=0x80AA_BBCC -> bus_addr_o=0x40, be=1000, stall_o high 4 cycles, result_o=0xFFFF_FF80; repeat with LBU -> 0x0000_0080.
- SH upper half: addr=0x202, rs2=0xDEAD_BEEF -> bus_we_o=1, be=1100, wdata=0xBEEF_BEEF, on ack reg_write_o=0, fault_o=0.
- Misaligned LW: addr=0x101 -> bus_req_o never asserted, data_ready_o=1 and fault_o=1 next cycle, reg_write_o=0.
- Timeout: TIMEOUT=4, load with no ack -> bus_req_o drops after 4 wait cycles, data_ready_o=1, fault_o=1; repeat with ack on the 4th cycle -> no fault.
- Flush/reset mid-transaction: clear_i pulsed in BUS_WAIT then ack -> data_ready_o stays 0; rst_i in BUS_WAIT -> bus_req_o=0 and stall_o=0 the next cycle.

Source files
------------

// File: rtl/rv32i_mem_pipe.sv
// RV32I memory-access stage: ALU pass-through, loads and stores over a
// single-outstanding req/ack bus, with upstream stall while a request is open.
module rv32i_mem_pipe #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              data_ready_i,
   input  logic [1:0]        mem_op_i,
   input  logic [2:0]        funct3_i,
   input  logic [XLEN-1:0]   alu_result_i,
   input  logic [XLEN-1:0]   store_data_i,
   input  logic [4:0]        rd_i,
   input  logic              reg_write_i,
   input  logic              clear_i,
   output logic              stall_o,
   output logic              data_ready_o,
   output logic [XLEN-1:0]   result_o,
   output logic [4:0]        rd_o,
   output logic              reg_write_o,
   output logic              fault_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [XLEN-3:0]   bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [XLEN-1:0]   bus_wdata_o,
   input  logic [XLEN-1:0]   bus_rdata_i,
   input  logic              bus_ack_i
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT);

   typedef enum logic [0:0] {IDLE, BUS_WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;
   logic             is_load_q;
   logic [4:0]       rd_q;
   logic             rw_q;
   logic             flush_q;

   logic             is_load_c;
   logic             is_store_c;
   logic             legal_c;
   logic             aligned_c;
   logic [3:0]       be_c;
   logic [XLEN-1:0]  wdata_c;
   logic             timeout_c;
   logic [XLEN-1:0]  lane_c;
   logic [7:0]       byte_c;
   logic [15:0]      half_c;
   logic [XLEN-1:0]  load_c;

   // Request decode: legality, alignment, byte enables and replicated store data
   always_comb begin
      is_load_c  = (mem_op_i == 2'b01);
      is_store_c = (mem_op_i == 2'b10);
      legal_c    = 1'b0;
      aligned_c  = 1'b1;
      be_c       = 4'b1111;
      wdata_c    = store_data_i;
      if (is_load_c)
         legal_c = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b101);
      else if (is_store_c)
         legal_c = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
      case (funct3_i[1:0])
         2'b00: begin
            be_c    = 4'b0001 << alu_result_i[1:0];
            wdata_c = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            aligned_c = ~alu_result_i[0];
            be_c      = alu_result_i[1] ? 4'b1100 : 4'b0011;
            wdata_c   = {2{store_data_i[15:0]}};
         end
         default: begin
            aligned_c = (alu_result_i[1:0] == 2'b00);
            be_c      = 4'b1111;
            wdata_c   = store_data_i;
         end
      endcase
   end

   // Load lane select and extension from the latched width and byte offset
   always_comb begin
      lane_c = bus_rdata_i >> {off_q, 3'b000};
      byte_c = lane_c[7:0];
      half_c = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
      case (f3_q)
         3'b000:  load_c = {{(XLEN-8){byte_c[7]}}, byte_c};
         3'b100:  load_c = {{(XLEN-8){1'b0}}, byte_c};
         3'b001:  load_c = {{(XLEN-16){half_c[15]}}, half_c};
         3'b101:  load_c = {{(XLEN-16){1'b0}}, half_c};
         default: load_c = bus_rdata_i;
      endcase
   end

   // The counter reaches TIMEOUT on the cycle it would increment to it
   assign timeout_c = (({1'b0, cnt} + (CNT_W+1)'(1)) == TIMEOUT_LIM);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         cnt          <= '0;
         f3_q         <= '0;
         off_q        <= '0;
         is_load_q    <= 1'b0;
         rd_q         <= '0;
         rw_q         <= 1'b0;
         flush_q      <= 1'b0;
         stall_o      <= 1'b0;
         data_ready_o <= 1'b0;
         result_o     <= '0;
         rd_o         <= '0;
         reg_write_o  <= 1'b0;
         fault_o      <= 1'b0;
         bus_req_o    <= 1'b0;
         bus_we_o     <= 1'b0;
         bus_addr_o   <= '0;
         bus_be_o     <= '0;
         bus_wdata_o  <= '0;
      end else begin
         data_ready_o <= 1'b0;
         fault_o      <= 1'b0;
         case (state)
            IDLE: begin
               if (data_ready_i && !clear_i) begin
                  if (!(is_load_c || is_store_c)) begin
                     data_ready_o <= 1'b1;
                     result_o     <= alu_result_i;
                     rd_o         <= rd_i;
                     reg_write_o  <= reg_write_i;
                  end else if (legal_c && aligned_c) begin
                     state       <= BUS_WAIT;
                     stall_o     <= 1'b1;
                     cnt         <= '0;
                     bus_req_o   <= 1'b1;
                     bus_we_o    <= is_store_c;
                     bus_addr_o  <= alu_result_i[XLEN-1:2];
                     bus_be_o    <= be_c;
                     bus_wdata_o <= wdata_c;
                     f3_q        <= funct3_i;
                     off_q       <= alu_result_i[1:0];
                     is_load_q   <= is_load_c;
                     rd_q        <= rd_i;
                     rw_q        <= reg_write_i;
                     flush_q     <= 1'b0;
                  end else begin
                     data_ready_o <= 1'b1;
                     fault_o      <= 1'b1;
                     result_o     <= alu_result_i;
                     rd_o         <= rd_i;
                     reg_write_o  <= 1'b0;
                  end
               end
            end
            BUS_WAIT: begin
               if (clear_i)
                  flush_q <= 1'b1;
               if (bus_ack_i || timeout_c) begin
                  state     <= IDLE;
                  stall_o   <= 1'b0;
                  bus_req_o <= 1'b0;
                  bus_we_o  <= 1'b0;
                  cnt       <= '0;
                  flush_q   <= 1'b0;
                  // A flush seen at any point during the wait silences completion
                  if (!(flush_q || clear_i)) begin
                     data_ready_o <= 1'b1;
                     rd_o         <= rd_q;
                     if (bus_ack_i) begin
                        result_o    <= is_load_q ? load_c : '0;
                        reg_write_o <= is_load_q & rw_q;
                     end else begin
                        fault_o     <= 1'b1;
                        result_o    <= '0;
                        reg_write_o <= 1'b0;
                     end
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_mem_pipe.sv
// Scoreboard bench for rv32i_mem_pipe: expected writebacks are queued at issue
// and compared when data_ready_o pulses; bus fields are checked at issue.
module tb_rv32i_mem_pipe;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        data_ready_i;
   logic [1:0]  mem_op_i;
   logic [2:0]  funct3_i;
   logic [31:0] alu_result_i;
   logic [31:0] store_data_i;
   logic [4:0]  rd_i;
   logic        reg_write_i;
   logic        clear_i;
   logic        stall_o;
   logic        data_ready_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;
   logic        reg_write_o;
   logic        fault_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [29:0] bus_addr_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        rw;
      logic        fault;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   sc;

   always #5 clk_i = ~clk_i;

   rv32i_mem_pipe #(.XLEN(32), .TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_ready_i(data_ready_i), .mem_op_i(mem_op_i),
      .funct3_i(funct3_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
      .rd_i(rd_i), .reg_write_i(reg_write_i), .clear_i(clear_i), .stall_o(stall_o),
      .data_ready_o(data_ready_o), .result_o(result_o), .rd_o(rd_o),
      .reg_write_o(reg_write_o), .fault_o(fault_o), .bus_req_o(bus_req_o),
      .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
      .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                           input logic flt);
      exp_t e;
      e.result = res;
      e.rd     = rd;
      e.rw     = rw;
      e.fault  = flt;
      sb_q.push_back(e);
   endtask

   // Writeback monitor
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (fault_o)
            chk("fault_with_valid", 32'(data_ready_o), 32'd1);
         if (data_ready_o) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out", 32'(data_ready_o), 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("result", result_o, e.result);
               chk("rd", 32'(rd_o), 32'(e.rd));
               chk("reg_write", 32'(reg_write_o), 32'(e.rw));
               chk("fault", 32'(fault_o), 32'(e.fault));
            end
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                        input logic clr);
      data_ready_i = 1'b1;
      mem_op_i     = op;
      funct3_i     = f3;
      alu_result_i = addr;
      store_data_i = sd;
      rd_i         = rd;
      reg_write_i  = rw;
      clear_i      = clr;
      @(posedge clk_i); #1;
      data_ready_i = 1'b0;
      mem_op_i     = 2'b00;
      clear_i      = 1'b0;
   endtask

   // Counts stall cycles; acks on wait cycle ack_at (negative: never ack)
   task automatic run_bus(input int ack_at, input logic [31:0] rdata, output int stall_cnt);
      stall_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (!stall_o) break;
         stall_cnt++;
         if (c == ack_at) begin
            bus_ack_i   = 1'b1;
            bus_rdata_i = rdata;
         end
         @(posedge clk_i); #1;
         bus_ack_i = 1'b0;
      end
   endtask

   task automatic idle_cycle();
      @(posedge clk_i); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; data_ready_i = 1'b0; mem_op_i = '0; funct3_i = '0; alu_result_i = '0;
      store_data_i = '0; rd_i = '0; reg_write_i = 1'b0; clear_i = 1'b0;
      bus_rdata_i = '0; bus_ack_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_valid", 32'(data_ready_o), 32'd0);
      chk("rst_req", 32'(bus_req_o), 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_fault", 32'(fault_o), 32'd0);

      // ALU pass-through and reserved op
      push_exp(32'h0000_1234, 5'd5, 1'b1, 1'b0);
      issue(2'b00, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0);
      chk("pt_stall", 32'(stall_o), 32'd0);
      chk("pt_req", 32'(bus_req_o), 32'd0);
      push_exp(32'hCAFE_0001, 5'd7, 1'b1, 1'b0);
      issue(2'b11, 3'b010, 32'hCAFE_0001, 32'h0, 5'd7, 1'b1, 1'b0);
      chk("rsv_req", 32'(bus_req_o), 32'd0);
      idle_cycle();

      // LB sign extension, ack on the 4th wait cycle (coincides with TIMEOUT)
      push_exp(32'hFFFF_FF80, 5'd3, 1'b1, 1'b0);
      issue(2'b01, 3'b000, 32'h0000_0103, 32'h0, 5'd3, 1'b1, 1'b0);
      chk("lb_req", 32'(bus_req_o), 32'd1);
      chk("lb_we", 32'(bus_we_o), 32'd0);
      chk("lb_addr", 32'(bus_addr_o), 32'h40);
      chk("lb_be", 32'(bus_be_o), 32'b1000);
      run_bus(3, 32'h80AA_BBCC, sc);
      chk("lb_stall_cycles", 32'(sc), 32'd4);
      chk("lb_req_drop", 32'(bus_req_o), 32'd0);
      idle_cycle();
      chk("lb_result_hold", result_o, 32'hFFFF_FF80);

      push_exp(32'h0000_0080, 5'd3, 1'b1, 1'b0);
      issue(2'b01, 3'b100, 32'h0000_0103, 32'h0, 5'd3, 1'b1, 1'b0);
      run_bus(3, 32'h80AA_BBCC, sc);
      chk("lbu_stall_cycles", 32'(sc), 32'd4);

      // SH upper half
      push_exp(32'h0, 5'd9, 1'b0, 1'b0);
      issue(2'b10, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0);
      chk("sh_we", 32'(bus_we_o), 32'd1);
      chk("sh_addr", 32'(bus_addr_o), 32'h80);
      chk("sh_be", 32'(bus_be_o), 32'b1100);
      chk("sh_wdata", bus_wdata_o, 32'hBEEF_BEEF);
      run_bus(1, 32'h0, sc);
      chk("sh_stall_cycles", 32'(sc), 32'd2);

      // SB byte lane 1, immediate ack
      push_exp(32'h0, 5'd10, 1'b0, 1'b0);
      issue(2'b10, 3'b000, 32'h0000_0301, 32'h1234_5678, 5'd10, 1'b1, 1'b0);
      chk("sb_be", 32'(bus_be_o), 32'b0010);
      chk("sb_wdata", bus_wdata_o, 32'h7878_7878);
      run_bus(0, 32'h0, sc);
      chk("sb_stall_cycles", 32'(sc), 32'd1);

      // Halfword and word loads
      push_exp(32'hFFFF_8001, 5'd11, 1'b1, 1'b0);
      issue(2'b01, 3'b001, 32'h0000_0402, 32'h0, 5'd11, 1'b1, 1'b0);
      chk("lh_be", 32'(bus_be_o), 32'b1100);
      run_bus(1, 32'h8001_7FFF, sc);
      push_exp(32'h0000_7FFF, 5'd12, 1'b1, 1'b0);
      issue(2'b01, 3'b101, 32'h0000_0400, 32'h0, 5'd12, 1'b1, 1'b0);
      chk("lhu_be", 32'(bus_be_o), 32'b0011);
      run_bus(2, 32'h8001_7FFF, sc);
      push_exp(32'h1357_9BDF, 5'd13, 1'b0, 1'b0);
      issue(2'b01, 3'b010, 32'h0000_0404, 32'h0, 5'd13, 1'b0, 1'b0);
      chk("lw_be", 32'(bus_be_o), 32'b1111);
      run_bus(0, 32'h1357_9BDF, sc);

      // Misaligned and illegal funct3: fault without a bus request
      push_exp(32'h0000_0101, 5'd4, 1'b0, 1'b1);
      issue(2'b01, 3'b010, 32'h0000_0101, 32'h0, 5'd4, 1'b1, 1'b0);
      chk("mis_req", 32'(bus_req_o), 32'd0);
      chk("mis_stall", 32'(stall_o), 32'd0);
      push_exp(32'h0000_0100, 5'd4, 1'b0, 1'b1);
      issue(2'b01, 3'b011, 32'h0000_0100, 32'h0, 5'd4, 1'b1, 1'b0);
      chk("ill_ld_req", 32'(bus_req_o), 32'd0);
      push_exp(32'h0000_0108, 5'd4, 1'b0, 1'b1);
      issue(2'b10, 3'b100, 32'h0000_0108, 32'h5, 5'd4, 1'b1, 1'b0);
      chk("ill_st_req", 32'(bus_req_o), 32'd0);
      idle_cycle();

      // Timeout with no ack
      push_exp(32'h0, 5'd6, 1'b0, 1'b1);
      issue(2'b01, 3'b010, 32'h0000_0500, 32'h0, 5'd6, 1'b1, 1'b0);
      run_bus(-1, 32'h0, sc);
      chk("to_stall_cycles", 32'(sc), 32'd4);
      chk("to_req_drop", 32'(bus_req_o), 32'd0);
      idle_cycle();

      // Clear in IDLE suppresses the input
      issue(2'b00, 3'b000, 32'h0000_0BAD, 32'h0, 5'd1, 1'b1, 1'b1);
      chk("clr_idle_req", 32'(bus_req_o), 32'd0);
      issue(2'b01, 3'b010, 32'h0000_0600, 32'h0, 5'd1, 1'b1, 1'b1);
      chk("clr_idle_ld_req", 32'(bus_req_o), 32'd0);

      // Flush during BUS_WAIT: transaction completes silently
      issue(2'b01, 3'b010, 32'h0000_0600, 32'h0, 5'd8, 1'b1, 1'b0);
      clear_i = 1'b1;
      idle_cycle();
      clear_i = 1'b0;
      chk("flush_still_busy", 32'(bus_req_o), 32'd1);
      run_bus(1, 32'h1111_2222, sc);
      chk("flush_done_stall", 32'(stall_o), 32'd0);
      idle_cycle();

      // Reset mid-transaction
      issue(2'b01, 3'b010, 32'h0000_0700, 32'h0, 5'd2, 1'b1, 1'b0);
      idle_cycle();
      rst_i = 1'b1;
      idle_cycle();
      rst_i = 1'b0;
      chk("rst_mid_req", 32'(bus_req_o), 32'd0);
      chk("rst_mid_stall", 32'(stall_o), 32'd0);
      chk("rst_mid_result", result_o, 32'd0);

      push_exp(32'h0000_00AB, 5'd31, 1'b1, 1'b0);
      issue(2'b00, 3'b000, 32'h0000_00AB, 32'h0, 5'd31, 1'b1, 1'b0);
      repeat (3) idle_cycle();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
